// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: channel mode encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package led_pwm_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_ON      = 2'd1;
    localparam mode_t MODE_FIXED   = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: double-buffered mode/duty config, level select, PWM compare.
// Latency: led is registered, one cycle after the pwm_cnt value it reflects.
// Backpressure: none; writes always accepted, last write before a boundary wins.
//
// Ports: clk/rst_n (async active-low); wr_en/wr_mode/wr_duty = decoded config
// write for this channel; period_end = commit strobe; pwm_cnt/brt_cnt = shared
// counters; pend = write waiting for boundary; led = registered drive.
// Build option: LED_PWM_GAMMA_EN squares the breathing triangle.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  mode_t               wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS:0]   brt_cnt,
    output logic                pend,
    output logic                led
);

    mode_t               pend_mode_q, pend_mode_d;
    logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
    logic                pend_q, pend_d;
    mode_t               act_mode_q, act_mode_d;
    logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
    logic                led_q, led_d;

    logic [PWM_BITS:0]   phase;
    logic [PWM_BITS-1:0] tri_lvl;
    logic [PWM_BITS-1:0] breathe_lvl;

    // A write landing on the boundary goes straight to active and drops any
    // older pending value, so the pend flag never shows it.
    always_comb begin
        pend_mode_d = pend_mode_q;
        pend_duty_d = pend_duty_q;
        pend_d      = pend_q;
        act_mode_d  = act_mode_q;
        act_duty_d  = act_duty_q;
        if (period_end) begin
            pend_d = 1'b0;
            if (wr_en) begin
                act_mode_d = wr_mode;
                act_duty_d = wr_duty;
            end else if (pend_q) begin
                act_mode_d = pend_mode_q;
                act_duty_d = pend_duty_q;
            end
        end else if (wr_en) begin
            pend_mode_d = wr_mode;
            pend_duty_d = wr_duty;
            pend_d      = 1'b1;
        end
    end

    // Duty doubles as phase offset in BREATHE; the doubled offset spans the
    // full up/down triangle so duty = half-scale lands on the opposite slope.
    always_comb begin
        phase   = brt_cnt + {act_duty_q, 1'b0};
        tri_lvl = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] tri_sq;
    always_comb begin
        tri_sq      = {{PWM_BITS{1'b0}}, tri_lvl} * {{PWM_BITS{1'b0}}, tri_lvl};
        breathe_lvl = tri_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        breathe_lvl = tri_lvl;
    end
`endif

    always_comb begin
        led_d = 1'b0;
        case (act_mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_FIXED: led_d = (pwm_cnt < act_duty_q);
            default:    led_d = (pwm_cnt < breathe_lvl);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mode_q <= MODE_OFF;
            pend_duty_q <= '0;
            pend_q      <= 1'b0;
            act_mode_q  <= MODE_OFF;
            act_duty_q  <= '0;
            led_q       <= 1'b0;
        end else begin
            pend_mode_q <= pend_mode_d;
            pend_duty_q <= pend_duty_d;
            pend_q      <= pend_d;
            act_mode_q  <= act_mode_d;
            act_duty_q  <= act_duty_d;
            led_q       <= led_d;
        end
    end

    assign pend = pend_q;
    assign led  = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel status-LED PWM: shared prescaler/PWM counter/breathing triangle.
// Latency: config commits at the next PWM period end; led registered (1 cycle).
// Backpressure: none; cfg writes always accepted, cfg_ch >= NUM_CH dropped.
//
// Ports: CLOCK_50 clock; reset async active-low; cfg_we/cfg_ch/cfg_mode/cfg_duty
// configuration write; cfg_pend per-channel uncommitted-write flags; led drives.
// Build option: LED_PWM_GAMMA_EN (gamma-corrected breathing, in led_pwm_chan).
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 4,
    parameter int BREATHE_DIV = 64,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  mode_t               cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [NUM_CH-1:0]   cfg_pend,
    output logic [NUM_CH-1:0]   led
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIV_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

    logic [PS_W-1:0]     ps_cnt_q, ps_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS:0]   brt_cnt_q, brt_cnt_d;

    logic tick;
    logic period_end;
    logic div_wrap;
    logic cfg_ok;

    always_comb begin
        tick       = (ps_cnt_q == PS_W'(PRESCALE - 1));
        period_end = tick && (&pwm_cnt_q);
        div_wrap   = period_end && (div_cnt_q == DIV_W'(BREATHE_DIV - 1));

        ps_cnt_d  = tick ? '0 : ps_cnt_q + PS_W'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        div_cnt_d = div_cnt_q;
        if (period_end) begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        end
        brt_cnt_d = div_wrap ? brt_cnt_q + (PWM_BITS+1)'(1) : brt_cnt_q;

        // cfg_ch can encode more values than there are channels when NUM_CH
        // is not a power of two.
        cfg_ok = cfg_we && ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CH));
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ps_cnt_q  <= '0;
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            brt_cnt_q <= '0;
        end else begin
            ps_cnt_q  <= ps_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            brt_cnt_q <= brt_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk        (CLOCK_50),
            .rst_n      (reset),
            .wr_en      (cfg_ok && (cfg_ch == CH_W'(i))),
            .wr_mode    (cfg_mode),
            .wr_duty    (cfg_duty),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt_q),
            .brt_cnt    (brt_cnt_q),
            .pend       (cfg_pend[i]),
            .led        (led[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank (3 channels, 4-bit PWM, no prescale).
// A cycle model pushes expected {cfg_pend, led} each rising edge; scenario
// tasks pop and compare on the falling edge and add scenario-specific checks.
module tb_led_pwm_bank;
    import led_pwm_pkg::*;

    localparam int NCH = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       cfg_we   = 1'b0;
    logic [1:0] cfg_ch   = 2'd0;
    mode_t      cfg_mode = MODE_OFF;
    logic [3:0] cfg_duty = 4'd0;
    logic [2:0] cfg_pend;
    logic [2:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    led_pwm_bank #(
        .NUM_CH(NCH), .PWM_BITS(4), .PRESCALE(1), .BREATHE_DIV(1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_duty (cfg_duty),
        .cfg_pend (cfg_pend),
        .led      (led)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model + scoreboard ----------------
    logic [3:0] m_pwm;
    logic [4:0] m_brt;
    logic [1:0] m_amode [NCH];
    logic [1:0] m_pmode [NCH];
    logic [3:0] m_aduty [NCH];
    logic [3:0] m_pduty [NCH];
    logic [2:0] m_pend, m_led;
    logic       m_pe, m_wr;
    logic [5:0] exp_q [$];
    logic [5:0] exp_v;

    function automatic logic [3:0] gam(input logic [3:0] t);
`ifdef LED_PWM_GAMMA_EN
        logic [7:0] sq;
        sq = t * t;
        return sq[7:4];
`else
        return t;
`endif
    endfunction

    function automatic logic [3:0] blvl(input logic [3:0] d, input logic [4:0] b);
        logic [4:0] p;
        p = b + {d, 1'b0};
        return gam(p[4] ? ~p[3:0] : p[3:0]);
    endfunction

    always @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            m_pwm = 4'd0; m_brt = 5'd0; m_pend = 3'd0; m_led = 3'd0;
            for (int i = 0; i < NCH; i++) begin
                m_amode[i] = MODE_OFF; m_pmode[i] = MODE_OFF;
                m_aduty[i] = 4'd0;     m_pduty[i] = 4'd0;
            end
        end else begin
            m_pe = (m_pwm == 4'hF);
            for (int i = 0; i < NCH; i++) begin
                case (m_amode[i])
                    MODE_OFF:   m_led[i] = 1'b0;
                    MODE_ON:    m_led[i] = 1'b1;
                    MODE_FIXED: m_led[i] = (m_pwm < m_aduty[i]);
                    default:    m_led[i] = (m_pwm < blvl(m_aduty[i], m_brt));
                endcase
                m_wr = cfg_we && (int'(cfg_ch) == i);
                if (m_pe) begin
                    if (m_wr) begin
                        m_amode[i] = cfg_mode; m_aduty[i] = cfg_duty;
                    end else if (m_pend[i]) begin
                        m_amode[i] = m_pmode[i]; m_aduty[i] = m_pduty[i];
                    end
                    m_pend[i] = 1'b0;
                end else if (m_wr) begin
                    m_pmode[i] = cfg_mode; m_pduty[i] = cfg_duty; m_pend[i] = 1'b1;
                end
            end
            m_pwm = m_pwm + 4'd1;
            if (m_pe) m_brt = m_brt + 5'd1;
            exp_q.push_back({m_pend, m_led});
        end
    end

    // Advance to the next falling edge, drop the write strobe, fetch expectation.
    task automatic step();
        @(negedge CLOCK_50);
        cfg_we = 1'b0;
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        else                   exp_v = 6'bxxxxxx;
    endtask

    task automatic wr(input logic [1:0] ch, input mode_t md, input logic [3:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = md; cfg_duty = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        n_tests++;
        if (led !== 3'b000) begin n_fail++; $display("FAIL reset_led: got %b exp 000", led); end
        n_tests++;
        if (cfg_pend !== 3'b000) begin n_fail++; $display("FAIL reset_pend: got %b exp 000", cfg_pend); end
        reset = 1'b1;
        exp_q.delete();
        wr(2'd1, MODE_ON, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL reset_sb: cyc %0d got %b exp %b", k, {cfg_pend, led}, exp_v); end
            if (k == 1 || k == 15) begin
                n_tests++;
                if (cfg_pend !== 3'b010) begin n_fail++; $display("FAIL reset_pend_hold: cyc %0d got %b exp 010", k, cfg_pend); end
            end
            if (k == 16) begin
                n_tests++;
                if (cfg_pend !== 3'b000 || led[1] !== 1'b0) begin n_fail++; $display("FAIL reset_first_boundary: pend %b led1 %b exp 000/0", cfg_pend, led[1]); end
            end
            if (k == 17) begin
                n_tests++;
                if (led[1] !== 1'b1) begin n_fail++; $display("FAIL reset_on_led: got %b exp 1", led[1]); end
            end
        end
    endtask

    task automatic test_fixed();
        int cnt;
        for (int k = 0; k < 40 && m_pwm != 4'd6; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL fixed_sync: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        wr(2'd0, MODE_FIXED, 4'd4);
        step();
        n_tests++;
        if (cfg_pend !== 3'b001) begin n_fail++; $display("FAIL fixed_pend_set: got %b exp 001", cfg_pend); end
        for (int k = 0; k < 40 && m_pwm != 4'd0; k++) begin
            step();
            n_tests++;
            if (cfg_pend[0] !== (m_pwm != 4'd0)) begin n_fail++; $display("FAIL fixed_pend_clear: pwm %0d got %b", m_pwm, cfg_pend[0]); end
        end
        cnt = 0;
        for (int j = 0; j < 32; j++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL fixed_sb: got %b exp %b", {cfg_pend, led}, exp_v); end
            n_tests++;
            if (led[0] !== ((j % 16) < 4)) begin n_fail++; $display("FAIL fixed_shape: slot %0d got %b", j % 16, led[0]); end
            cnt += int'(led[0]);
            if (j % 16 == 15) begin
                n_tests++;
                if (cnt != 4) begin n_fail++; $display("FAIL fixed_count: got %0d exp 4", cnt); end
                cnt = 0;
            end
        end
    endtask

    task automatic test_coincident();
        for (int k = 0; k < 40 && m_pwm != 4'd15; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL coin_sync: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        wr(2'd1, MODE_OFF, 4'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL coin_sb: got %b exp %b", {cfg_pend, led}, exp_v); end
            n_tests++;
            if (cfg_pend[1] !== 1'b0 || led[1] !== (k == 0)) begin n_fail++; $display("FAIL coin_off: cyc %0d pend1 %b led1 %b", k, cfg_pend[1], led[1]); end
        end
        wr(2'd1, MODE_ON, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (cfg_pend[1] !== 1'b0 || led[1] !== (k != 0)) begin n_fail++; $display("FAIL coin_on: cyc %0d pend1 %b led1 %b", k, cfg_pend[1], led[1]); end
        end
    endtask

    task automatic test_overwrite();
        for (int k = 0; k < 40 && m_pwm != 4'd3; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL ovw_sync: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        wr(2'd0, MODE_FIXED, 4'd9);
        step();
        wr(2'd0, MODE_OFF, 4'd0);
        step();
        wr(2'd3, MODE_FIXED, 4'd5);
        step();
        n_tests++;
        if (cfg_pend !== 3'b001) begin n_fail++; $display("FAIL ovw_pend: got %b exp 001", cfg_pend); end
        for (int k = 0; k < 40 && m_pwm != 4'd0; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL ovw_sb: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        n_tests++;
        if (cfg_pend !== 3'b000) begin n_fail++; $display("FAIL ovw_commit: got %b exp 000", cfg_pend); end
        for (int k = 0; k < 16; k++) begin
            step();
            n_tests++;
            if (led !== 3'b010) begin n_fail++; $display("FAIL ovw_led: cyc %0d got %b exp 010", k, led); end
        end
    endtask

    task automatic test_breathe();
        int c0, c1, first, t0;
        logic [3:0] e0, e1;
        for (int k = 0; k < 40 && m_pwm != 4'd8; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL brt_sync: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        wr(2'd0, MODE_BREATHE, 4'd0);
        step();
        wr(2'd1, MODE_BREATHE, 4'd8);
        step();
        n_tests++;
        if (cfg_pend !== 3'b011) begin n_fail++; $display("FAIL brt_pend: got %b exp 011", cfg_pend); end
        for (int k = 0; k < 40 && m_pwm != 4'd0; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL brt_sync2: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        first = -1;
        for (int p = 0; p <= 32; p++) begin
            t0 = (int'(m_brt) < 16) ? int'(m_brt) : 31 - int'(m_brt);
            c0 = 0; c1 = 0;
            for (int j = 0; j < 16; j++) begin
                step();
                n_tests++;
                if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL brt_sb: got %b exp %b", {cfg_pend, led}, exp_v); end
                c0 += int'(led[0]);
                c1 += int'(led[1]);
            end
            e0 = gam(4'(t0));
            e1 = gam(4'(15 - t0));
            n_tests++;
            if (c0 != int'(e0) || c1 != int'(e1)) begin n_fail++; $display("FAIL brt_level: tri %0d got %0d/%0d exp %0d/%0d", t0, c0, c1, e0, e1); end
`ifdef LED_PWM_GAMMA_EN
            if (t0 == 8)  begin n_tests++; if (c0 != 4)  begin n_fail++; $display("FAIL gamma_t8: got %0d exp 4", c0); end end
            if (t0 == 15) begin n_tests++; if (c0 != 14) begin n_fail++; $display("FAIL gamma_t15: got %0d exp 14", c0); end end
`else
            if (t0 == 0)  begin n_tests++; if (c0 != 0 || c1 != 15) begin n_fail++; $display("FAIL brt_anti: got %0d/%0d exp 0/15", c0, c1); end end
`endif
            if (p == 0) first = c0;
            if (p == 32) begin
                n_tests++;
                if (c0 != first) begin n_fail++; $display("FAIL brt_repeat: got %0d exp %0d", c0, first); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40 && m_pwm != 4'd5; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL rmid_sync: got %b exp %b", {cfg_pend, led}, exp_v); end
        end
        wr(2'd2, MODE_FIXED, 4'd3);
        step();
        n_tests++;
        if (cfg_pend !== 3'b100) begin n_fail++; $display("FAIL rmid_pend: got %b exp 100", cfg_pend); end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (led !== 3'b000 || cfg_pend !== 3'b000) begin n_fail++; $display("FAIL rmid_async: led %b pend %b exp 000/000", led, cfg_pend); end
        repeat (2) @(negedge CLOCK_50);
        exp_q.delete();
        reset = 1'b1;
        wr(2'd0, MODE_ON, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            n_tests++;
            if ({cfg_pend, led} !== exp_v) begin n_fail++; $display("FAIL rmid_sb: cyc %0d got %b exp %b", k, {cfg_pend, led}, exp_v); end
            if (k == 15 || k == 16) begin
                n_tests++;
                if (cfg_pend !== ((k == 15) ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL rmid_restart: cyc %0d pend %b", k, cfg_pend); end
            end
            if (k == 17) begin
                n_tests++;
                if (led !== 3'b001) begin n_fail++; $display("FAIL rmid_led: got %b exp 001", led); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_coincident();
        test_overwrite();
        test_breathe();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
Multi-channel successor to the single-LED breathing PWM. NUM_CH independent LED outputs share one PWM counter and one breathing triangle generator. Each channel is configured at run time as OFF, ON, FIXED duty, or BREATHE with a per-channel phase offset. Configuration is double-buffered so that a change takes effect only at a PWM period boundary, which keeps the outputs glitch-free. The block sits at the board top level and drives the status LEDs.

Parameters:
NUM_CH, 4, number of LED channels (1..16)
PWM_BITS, 8, PWM resolution; the period is 2^PWM_BITS ticks
PRESCALE, 4, CLOCK_50 cycles per PWM tick (>=1)
BREATHE_DIV, 64, PWM periods per breathing-triangle step (>=1)

Ports:
CLOCK_50  in  1  system clock; every register is on its rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  single-cycle configuration write strobe
cfg_ch  in  clog2(NUM_CH) (min 1)  target channel; writes with cfg_ch >= NUM_CH are ignored
cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 FIXED, 3 BREATHE
cfg_duty  in  PWM_BITS  FIXED: duty level; BREATHE: phase offset
cfg_pend  out  NUM_CH  per-channel flag: a write is pending, not yet committed
led  out  NUM_CH  LED drive, active-high, registered

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters = 0.
  - Active and pending mode = OFF; duty = 0.
  - cfg_pend = 0; led = 0.
- Prescaler counts 0..PRESCALE-1. tick = (count == PRESCALE-1). With PRESCALE=1, tick fires every cycle.
- pwm_cnt (PWM_BITS wide) increments on tick and wraps.
- period_end = tick && (pwm_cnt == all-ones).
- Breathing divider counts period_end events 0..BREATHE_DIV-1. On its wrap, brt_cnt (PWM_BITS+1 wide) increments modulo 2^(PWM_BITS+1).
- Per-channel level:
  - OFF: led forced to 0.
  - ON: led forced to 1.
  - FIXED: level = duty.
  - BREATHE:
    - p = brt_cnt + {duty, 1'b0}, computed modulo 2^(PWM_BITS+1).
    - level = p[MSB] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0].
- Output rule for FIXED and BREATHE: led[i] <= (pwm_cnt < level). The output is registered, so there is one cycle of latency from pwm_cnt to led.
- Consequences: level 0 gives a constant 0; the maximum level gives high for 2^PWM_BITS - 1 of every 2^PWM_BITS ticks.
- Configuration write, cfg_we=1 with a valid cfg_ch:
  - mode and duty are captured into that channel's pending register.
  - cfg_pend[ch] is set on the next edge.
- A later write to the same channel before the boundary overwrites the pending values. Last write wins.
- Commit: on period_end, every channel with its pend flag set copies pending into active and clears its pend flag.
- A write in the same cycle as period_end bypasses the pending stage:
  - It commits at that boundary directly.
  - cfg_pend stays 0.
  - Any older pending value for that channel is discarded.
- Writes to different channels are independent. Only one write is possible per cycle.
- Reset asserted mid-period clears everything, including pending writes. After release, counting restarts from 0.

Optional Feature:
Macro LED_PWM_GAMMA_EN.
- Defined: BREATHE level = (t*t) >> PWM_BITS, where t is the triangle value. FIXED and OFF/ON modes are unchanged. This gives a perceptually linear fade.
- Undefined: the linear triangle is used as described above. The squarer is not synthesised.

Decomposition:
- Package led_pwm_pkg holds:
  - mode constants MODE_OFF, MODE_ON, MODE_FIXED, MODE_BREATHE;
  - the 2-bit mode typedef.
- Sub-module led_pwm_chan, one instance per channel, holds:
  - the pending and active registers;
  - the pend flag and commit logic;
  - the level mux, the gamma option, and the compare/output register.
- The top level holds the prescaler, pwm_cnt, the breathing divider, brt_cnt, and write decode.

Test Plan:
All scenarios use NUM_CH=2, PWM_BITS=4, PRESCALE=1, BREATHE_DIV=1 unless noted.
1. Reset held, then released -> led=00 and cfg_pend=00. After release, first period_end occurs on cycle 16 (pwm_cnt 15 with tick).
2. Write ch0 FIXED duty=4 mid-period -> cfg_pend=01 until the boundary, then cleared. In each following 16-cycle period, led[0] is high for exactly 4 cycles (pwm_cnt 0..3, seen one cycle later).
3. Write ch1 ON coincident with period_end -> cfg_pend[1] never asserts. led[1]=1 from the next cycle.
4. Write ch0 FIXED 4, then ch0 OFF, both before the boundary -> after the boundary led[0] stays 0. Write with cfg_ch=2 -> no state change.
5. Both channels BREATHE, ch0 phase 0, ch1 phase 8 -> ch0 level follows brt_cnt 0,1..15,15..0 per period. ch1 level = 15 when ch0 level = 0. The triangle repeats every 32 periods.
6. LED_PWM_GAMMA_EN defined, ch0 BREATHE at t=8 -> level 4 (high for 4 of 16 cycles). At t=15 -> level 14. Also assert reset mid-period with a write pending -> led=00, cfg_pend=00 immediately.
